udp_tx_packet_buffer: RTL and testbench

Store-and-forward packet buffer between the application core's `udp_tx_*` stream output and the UDP/IP transmit core. It accepts a packet of 32-bit words, holds it until its final word arrives, computes its byte length, and then replays it with a correct `last_be` mask and `out_length`. It drops packets that overflow the buffer or are truncated by a new `first`, so the transmit core never sees a partial frame.

---
 rtl/udp_tx_packet_buffer.sv | 272 +++++++++++++++++++++++++++
 tb/tb_udp_tx_packet_buffer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_packet_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : udp_tx_packet_buffer
//  Purpose  : Store-and-forward packet buffer between the application core's
//             udp_tx_* stream and the UDP/IP transmit core. A packet of 32-bit
//             words is held until its final word arrives. It is then replayed
//             with a cleaned-up last_be mask and a byte length. Overflowing or
//             truncated packets are dropped and counted.
//  Ports    : clk, rst (async, active-high)
//             in_valid/in_ready/in_first/in_last/in_payload[31:0]/in_last_be[3:0]
//             out_valid/out_ready/out_first/out_last/out_payload[31:0]
//             out_last_be[3:0], out_length[15:0], drop_count[15:0]
//  Revision : 1.0 - initial release
// ============================================================================
module udp_tx_packet_buffer #(
  parameter int ADDR_WIDTH = 9,
  parameter int SLOT_LOG2  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_first,
  input  logic        in_last,
  input  logic [31:0] in_payload,
  input  logic [3:0]  in_last_be,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_first,
  output logic        out_last,
  output logic [31:0] out_payload,
  output logic [3:0]  out_last_be,
  output logic [15:0] out_length,
  output logic [15:0] drop_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int SLOTS = 1 << SLOT_LOG2;
  localparam int CW    = ADDR_WIDTH + 1;   // word-count width (counts up to DEPTH)
  localparam int SW    = SLOT_LOG2 + 1;    // slot pointer width with wrap bit

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECV    = 2'd1,
    ST_DISCARD = 2'd2
  } wr_state_e;

  // Storage
  logic [31:0]   mem_q     [DEPTH];
  logic [CW-1:0] desc_wc_q [SLOTS];
  logic [3:0]    desc_be_q [SLOTS];

  // Write side state
  wr_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_commit_q, wr_commit_d;
  logic [ADDR_WIDTH-1:0] wr_tmp_q, wr_tmp_d;
  logic [CW-1:0]         part_q, part_d;   // words of the packet in progress
  logic [CW-1:0]         used_q, used_d;   // committed words still in RAM
  logic [SW-1:0]         tail_q;
  logic [15:0]           drop_count_q, drop_count_d;

  // Read side state
  logic [SW-1:0]         pop_q;       // oldest descriptor still owned by output
  logic [SW-1:0]         rd_head_q;   // descriptor currently being loaded
  logic [ADDR_WIDTH-1:0] rd_ptr_q;
  logic [CW-1:0]         rd_idx_q;
  logic                  out_valid_q, out_first_q, out_last_q;
  logic [31:0]           out_payload_q;
  logic [3:0]            out_last_be_q;
  logic [15:0]           out_length_q;

  // Write side combinational
  logic                  slots_full;
  logic                  in_fire;
  logic                  we;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  push;
  logic [CW-1:0]         push_wc;
  logic [3:0]            push_be;
  logic [1:0]            drop_inc;
  logic                  start_pkt;
  logic [16:0]           drop_sum;

  // Read side combinational
  logic                  desc_avail;
  logic [CW-1:0]         hd_wc;
  logic [3:0]            hd_be;
  logic [2:0]            hd_pop;
  logic [15:0]           hd_len;
  logic                  rd_last;
  logic                  load;
  logic                  out_fire;
  logic                  pop;

  // A descriptor stays counted until its last word leaves the output register,
  // so a stalled packet still occupies its slot.
  assign slots_full = ((tail_q - pop_q) == SW'(SLOTS));
  assign in_ready   = ~slots_full;
  assign in_fire    = in_valid & ~slots_full;
  assign push_be    = (in_last_be == 4'b0000) ? 4'hF : in_last_be;

  // --------------------------------------------------------------------------
  // Write FSM next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    wr_commit_d = wr_commit_q;
    wr_tmp_d    = wr_tmp_q;
    part_d      = part_q;
    we          = 1'b0;
    wr_addr     = wr_tmp_q;
    push        = 1'b0;
    push_wc     = '0;
    drop_inc    = 2'd0;
    start_pkt   = 1'b0;

    if (in_fire) begin
      unique case (state_q)
        ST_RECV: begin
          if (in_first) begin
            // Truncated by a new packet: drop the partial one, restart.
            drop_inc  = 2'd1;
            start_pkt = 1'b1;
          end else if ((used_q + part_q) == CW'(DEPTH)) begin
            drop_inc = 2'd1;
            wr_tmp_d = wr_commit_q;
            part_d   = '0;
            state_d  = in_last ? ST_IDLE : ST_DISCARD;
          end else begin
            we       = 1'b1;
            wr_addr  = wr_tmp_q;
            wr_tmp_d = wr_tmp_q + ADDR_WIDTH'(1);
            if (in_last) begin
              push        = 1'b1;
              push_wc     = part_q + CW'(1);
              wr_commit_d = wr_tmp_q + ADDR_WIDTH'(1);
              part_d      = '0;
              state_d     = ST_IDLE;
            end else begin
              part_d = part_q + CW'(1);
            end
          end
        end
        default: begin
          // IDLE and DISCARD: only a first beat starts a packet.
          if (in_first) begin
            start_pkt = 1'b1;
          end else if ((state_q == ST_DISCARD) && in_last) begin
            state_d = ST_IDLE;
          end
        end
      endcase

      // New packet always starts at the committed pointer (implicit rollback).
      if (start_pkt) begin
        if (used_q == CW'(DEPTH)) begin
          drop_inc = drop_inc + 2'd1;
          wr_tmp_d = wr_commit_q;
          part_d   = '0;
          state_d  = in_last ? ST_IDLE : ST_DISCARD;
        end else begin
          we       = 1'b1;
          wr_addr  = wr_commit_q;
          wr_tmp_d = wr_commit_q + ADDR_WIDTH'(1);
          if (in_last) begin
            push        = 1'b1;
            push_wc     = CW'(1);
            wr_commit_d = wr_commit_q + ADDR_WIDTH'(1);
            part_d      = '0;
            state_d     = ST_IDLE;
          end else begin
            part_d  = CW'(1);
            state_d = ST_RECV;
          end
        end
      end
    end
  end

  assign drop_sum     = {1'b0, drop_count_q} + {15'd0, drop_inc};
  assign drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

  // --------------------------------------------------------------------------
  // Read side
  // --------------------------------------------------------------------------
  assign desc_avail = (rd_head_q != tail_q);
  assign hd_wc      = desc_wc_q[rd_head_q[SLOT_LOG2-1:0]];
  assign hd_be      = desc_be_q[rd_head_q[SLOT_LOG2-1:0]];
  assign hd_pop     = {2'b00, hd_be[0]} + {2'b00, hd_be[1]}
                    + {2'b00, hd_be[2]} + {2'b00, hd_be[3]};
  assign hd_len     = ((16'(hd_wc) - 16'd1) << 2) + {13'd0, hd_pop};
  assign rd_last    = (rd_idx_q == (hd_wc - CW'(1)));
  assign out_fire   = out_valid_q & out_ready;
  assign load       = desc_avail & (~out_valid_q | out_ready);
  assign pop        = out_fire & out_last_q;

  // A word leaves RAM when it is loaded into the output register.
  assign used_d = used_q + (push ? push_wc : CW'(0)) - (load ? CW'(1) : CW'(0));

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wr_commit_q  <= '0;
      wr_tmp_q     <= '0;
      part_q       <= '0;
      used_q       <= '0;
      tail_q       <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_commit_q  <= wr_commit_d;
      wr_tmp_q     <= wr_tmp_d;
      part_q       <= part_d;
      used_q       <= used_d;
      tail_q       <= tail_q + SW'(push);
      drop_count_q <= drop_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_addr] <= in_payload;
    end
    if (push) begin
      desc_wc_q[tail_q[SLOT_LOG2-1:0]] <= push_wc;
      desc_be_q[tail_q[SLOT_LOG2-1:0]] <= push_be;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pop_q         <= '0;
      rd_head_q     <= '0;
      rd_ptr_q      <= '0;
      rd_idx_q      <= '0;
      out_valid_q   <= 1'b0;
      out_first_q   <= 1'b0;
      out_last_q    <= 1'b0;
      out_payload_q <= '0;
      out_last_be_q <= '0;
      out_length_q  <= '0;
    end else begin
      if (load) begin
        out_valid_q   <= 1'b1;
        out_first_q   <= (rd_idx_q == '0);
        out_last_q    <= rd_last;
        out_payload_q <= mem_q[rd_ptr_q];
        out_last_be_q <= rd_last ? hd_be : 4'hF;
        out_length_q  <= hd_len;
        rd_ptr_q      <= rd_ptr_q + ADDR_WIDTH'(1);
        rd_idx_q      <= rd_last ? '0 : (rd_idx_q + CW'(1));
        rd_head_q     <= rd_head_q + SW'(rd_last);
      end else if (out_fire) begin
        out_valid_q <= 1'b0;
      end
      pop_q <= pop_q + SW'(pop);
    end
  end

  assign out_valid   = out_valid_q;
  assign out_first   = out_first_q;
  assign out_last    = out_last_q;
  assign out_payload = out_payload_q;
  assign out_last_be = out_last_be_q;
  assign out_length  = out_length_q;
  assign drop_count  = drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_udp_tx_packet_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_udp_tx_packet_buffer
//  Purpose  : Directed self-checking bench for udp_tx_packet_buffer
//             (ADDR_WIDTH=4, SLOT_LOG2=2). Expected beats are queued by the
//             stimulus and compared by an output monitor.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_udp_tx_packet_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_first = 1'b0;
  logic        in_last = 1'b0;
  logic [31:0] in_payload = '0;
  logic [3:0]  in_last_be = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_first;
  logic        out_last;
  logic [31:0] out_payload;
  logic [3:0]  out_last_be;
  logic [15:0] out_length;
  logic [15:0] drop_count;

  always #5 clk = ~clk;

  udp_tx_packet_buffer #(.ADDR_WIDTH(4), .SLOT_LOG2(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first),
    .in_last(in_last), .in_payload(in_payload), .in_last_be(in_last_be),
    .out_valid(out_valid), .out_ready(out_ready), .out_first(out_first),
    .out_last(out_last), .out_payload(out_payload), .out_last_be(out_last_be),
    .out_length(out_length), .drop_count(drop_count)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [21:0] ctl;   // {first, last, last_be, length}
  } beat_t;

  beat_t       exp_q[$];
  beat_t       mon_e;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] snap_d;
  logic [21:0] snap_ctl;
  logic [21:0] mon_ctl;
  logic        gap_en = 1'b0;
  logic        gap_armed = 1'b0;
  int          gap = 0;
  logic        bp_done = 1'b0;
  logic        seen;

  assign mon_ctl = {out_first, out_last, out_last_be, out_length};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic exp_push(input logic [31:0] d, input logic f, input logic l,
                          input logic [3:0] be, input logic [15:0] len);
    beat_t b;
    b.d   = d;
    b.ctl = {f, l, be, len};
    exp_q.push_back(b);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_beat(input logic f, input logic l, input logic [31:0] d,
                           input logic [3:0] be);
    int t;
    t = 0;
    in_valid = 1'b1; in_first = f; in_last = l; in_payload = d; in_last_be = be;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_last_be = 4'h0;
  endtask

  task automatic send_pkt(input int n, input logic [7:0] tag, input logic [3:0] be,
                          input logic expect_out, input logic [15:0] len,
                          input logic [3:0] ebe);
    for (int i = 0; i < n; i++) begin
      if (expect_out)
        exp_push({tag, 24'(i)}, (i == 0), (i == n - 1), (i == n - 1) ? ebe : 4'hF, len);
    end
    for (int i = 0; i < n; i++)
      send_beat((i == 0), (i == n - 1), {tag, 24'(i)}, (i == n - 1) ? be : 4'h0);
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk(tag, 32'(exp_q.size()), 0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Output monitor: scoreboard compare, stall stability, inter-packet gap.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
      gap_armed  = 1'b0;
    end else if (out_valid) begin
      if (stall_prev) begin
        chk("stall_payload", out_payload, snap_d);
        chk("stall_ctl", 32'(mon_ctl), 32'(snap_ctl));
      end
      if (gap_en && gap_armed && out_first) begin
        chk("idle_gap_le1", 32'(gap <= 1), 1);
        gap_armed = 1'b0;
      end
      if (out_ready) begin
        stall_prev = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'(exp_q.size()), 1);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_payload", out_payload, mon_e.d);
          chk("out_ctl", 32'(mon_ctl), 32'(mon_e.ctl));
        end
        if (out_last) begin
          gap_armed = 1'b1;
          gap = 0;
        end
      end else begin
        stall_prev = 1'b1;
        snap_d     = out_payload;
        snap_ctl   = mon_ctl;
      end
    end else begin
      if (stall_prev) chk("valid_held", 32'(out_valid), 1);
      stall_prev = 1'b0;
      if (gap_armed) gap++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // Reset values
    @(negedge clk);
    chk("rst_out_valid",   32'(out_valid), 0);
    chk("rst_out_first",   32'(out_first), 0);
    chk("rst_out_last",    32'(out_last), 0);
    chk("rst_out_payload", out_payload, 0);
    chk("rst_out_last_be", 32'(out_last_be), 0);
    chk("rst_out_length",  32'(out_length), 0);
    chk("rst_drop_count",  32'(drop_count), 0);
    chk("rst_in_ready",    32'(in_ready), 1);
    @(posedge clk); #1 rst = 1'b0;

    // Single 3-word packet, latency
    exp_push(32'h01020304, 1'b1, 1'b0, 4'hF,    16'd10);
    exp_push(32'h05060708, 1'b0, 1'b0, 4'hF,    16'd10);
    exp_push(32'h090A0000, 1'b0, 1'b1, 4'b1100, 16'd10);
    send_beat(1'b1, 1'b0, 32'h01020304, 4'h0);
    send_beat(1'b0, 1'b0, 32'h05060708, 4'h0);
    send_beat(1'b0, 1'b1, 32'h090A0000, 4'b1100);
    @(negedge clk);
    seen = out_valid & out_first;
    @(negedge clk);
    chk("latency_n2", 32'(seen | (out_valid & out_first)), 1);
    wait_drain("drain_single");
    chk("single_drop", 32'(drop_count), 0);

    // Backpressure over 4 packets
    do_reset();
    fork
      begin
        send_pkt(3, 8'hA1, 4'b1000, 1'b1, 16'd9,  4'b1000);
        send_pkt(5, 8'hA2, 4'b1110, 1'b1, 16'd19, 4'b1110);
        send_pkt(1, 8'hA3, 4'b1111, 1'b1, 16'd4,  4'hF);
        send_pkt(7, 8'hA4, 4'b0001, 1'b1, 16'd25, 4'b0001);
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    wait_drain("drain_bp");

    // Back-to-back packets with out_ready held high
    gap_armed = 1'b0;
    gap_en    = 1'b1;
    send_pkt(2, 8'hB1, 4'hF, 1'b1, 16'd8, 4'hF);
    send_pkt(2, 8'hB2, 4'hF, 1'b1, 16'd8, 4'hF);
    wait_drain("drain_gap");
    gap_en = 1'b0;

    // Truncation
    do_reset();
    send_beat(1'b1, 1'b0, 32'hC1000000, 4'h0);
    send_beat(1'b0, 1'b0, 32'hC1000001, 4'h0);
    send_pkt(4, 8'hC2, 4'hF, 1'b1, 16'd16, 4'hF);
    wait_drain("drain_trunc");
    chk("trunc_drop", 32'(drop_count), 1);

    // Overflow, then an exactly-full packet into an empty buffer
    do_reset();
    send_pkt(20, 8'hD1, 4'hF, 1'b0, 16'd0, 4'hF);
    send_pkt(5,  8'hD2, 4'hF, 1'b1, 16'd20, 4'hF);
    wait_drain("drain_ovf");
    chk("ovf_drop", 32'(drop_count), 1);
    send_pkt(16, 8'hD3, 4'b0011, 1'b1, 16'd62, 4'b0011);
    wait_drain("drain_full16");
    chk("full16_drop", 32'(drop_count), 1);

    // Descriptor slots full
    do_reset();
    out_ready = 1'b0;
    send_pkt(1, 8'hE1, 4'hF, 1'b1, 16'd4, 4'hF);
    send_pkt(1, 8'hE2, 4'hF, 1'b1, 16'd4, 4'hF);
    send_pkt(1, 8'hE3, 4'hF, 1'b1, 16'd4, 4'hF);
    send_pkt(1, 8'hE4, 4'hF, 1'b1, 16'd4, 4'hF);
    @(negedge clk);
    chk("slots_full_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    fork
      send_pkt(1, 8'hE5, 4'hF, 1'b1, 16'd4, 4'hF);
      begin
        repeat (3) @(negedge clk);
        chk("slots_still_full", 32'(in_ready), 0);
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    wait_drain("drain_slots");

    // Async reset mid-output, then last_be = 0
    do_reset();
    out_ready = 1'b0;
    send_pkt(4, 8'hF1, 4'hF, 1'b0, 16'd0, 4'hF);
    repeat (3) @(negedge clk);
    chk("pre_rst_valid", 32'(out_valid), 1);
    #2 rst = 1'b1;
    #1 chk("async_rst_valid", 32'(out_valid), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("post_rst_quiet", 32'(out_valid), 0);
    chk("post_rst_drop", 32'(drop_count), 0);
    @(posedge clk); #1;
    send_pkt(1, 8'hF2, 4'b0000, 1'b1, 16'd4, 4'hF);
    wait_drain("drain_be0");

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
